space_race_sync_gen: RTL and testbench

// - Video timing transmitter for the Space Race core: produces CLK_VIDEO, HSYNC, VSYNC, HBLANK, VBLANK
//   and beam counters. Consumers are the game video logic and the emu top.
// - The emu top derives ce_pix from the rising edge of CLK_VIDEO and feeds arcade_video (WIDTH=375).
// - Runs from the 57.272 MHz system clock; the pixel rate is CLK_DRV/CLK_DIV, 7.159 MHz by default.

---
 rtl/space_race_sync_gen.sv | 186 ++++++++++++++++++
 tb/tb_space_race_sync_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/space_race_sync_gen.sv
// space_race_sync_gen
// Video timing generator for the Space Race core. A CLK_DIV divider running on
// CLK_DRV produces the pixel clock CLK_VIDEO and the PIX_CE strobe; the beam
// counters HCNT/VCNT and every sync/blank flag are registered and update on the
// PIX_CE edge, i.e. on the same edge CLK_VIDEO rises.
// Optional feature: define SPACE_RACE_SYNC_TESTPAT_EN to build the crosshatch
// TESTPAT decode; without it TESTPAT is a constant 0.
//
// Handshake note: there is no valid/ready traffic here. PIX_CE is a pure
// one-cycle strobe; consumers either use PIX_CE directly or the rising edge of
// CLK_VIDEO, and in both cases all beam outputs are stable for CLK_DIV-1 cycles
// after the edge on which they change.
module space_race_sync_gen #(
   parameter int CLK_DIV      = 8,
   parameter int H_TOTAL      = 455,
   parameter int H_ACTIVE     = 375,
   parameter int H_SYNC_START = 400,
   parameter int H_SYNC_W     = 32,
   parameter int V_TOTAL      = 262,
   parameter int V_ACTIVE     = 240,
   parameter int V_SYNC_START = 244,
   parameter int V_SYNC_W     = 4
) (
   input  logic       CLK_DRV,
   input  logic       RESET_N,
   output logic       CLK_VIDEO,
   output logic       PIX_CE,
   output logic [8:0] HCNT,
   output logic [8:0] VCNT,
   output logic       HSYNC,
   output logic       VSYNC,
   output logic       HBLANK,
   output logic       VBLANK,
   output logic       FRAME_START,
   output logic       TESTPAT
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if (((CLK_DIV % 2) != 0) || (CLK_DIV < 2)) begin : g_bad_clk_div
      $error("space_race_sync_gen: CLK_DIV=%0d must be even and >= 2", CLK_DIV);
   end
   if ((H_SYNC_START + H_SYNC_W) > H_TOTAL) begin : g_bad_hsync
      $error("space_race_sync_gen: H_SYNC_START+H_SYNC_W=%0d exceeds H_TOTAL=%0d",
             H_SYNC_START + H_SYNC_W, H_TOTAL);
   end
   if ((V_SYNC_START + V_SYNC_W) > V_TOTAL) begin : g_bad_vsync
      $error("space_race_sync_gen: V_SYNC_START+V_SYNC_W=%0d exceeds V_TOTAL=%0d",
             V_SYNC_START + V_SYNC_W, V_TOTAL);
   end
   if (H_ACTIVE > H_TOTAL) begin : g_bad_hactive
      $error("space_race_sync_gen: H_ACTIVE=%0d exceeds H_TOTAL=%0d", H_ACTIVE, H_TOTAL);
   end
   if (V_ACTIVE > V_TOTAL) begin : g_bad_vactive
      $error("space_race_sync_gen: V_ACTIVE=%0d exceeds V_TOTAL=%0d", V_ACTIVE, V_TOTAL);
   end
   if (H_TOTAL > 512) begin : g_bad_htotal
      $error("space_race_sync_gen: H_TOTAL=%0d does not fit a 9-bit counter", H_TOTAL);
   end
   if (V_TOTAL > 512) begin : g_bad_vtotal
      $error("space_race_sync_gen: V_TOTAL=%0d does not fit a 9-bit counter", V_TOTAL);
   end

   // ------------------------------------------------------------------
   // Constants sized to the counters they are compared against. The sync and
   // active limits use 10 bits so START+W = 512 still compares correctly.
   // ------------------------------------------------------------------
   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

   localparam logic [8:0] H_LAST   = 9'(H_TOTAL - 1);
   localparam logic [8:0] V_LAST   = 9'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT_L  = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT_L  = 10'(V_ACTIVE);
   localparam logic [9:0] H_HS_LO  = 10'(H_SYNC_START);
   localparam logic [9:0] H_HS_HI  = 10'(H_SYNC_START + H_SYNC_W);
   localparam logic [9:0] V_VS_LO  = 10'(V_SYNC_START);
   localparam logic [9:0] V_VS_HI  = 10'(V_SYNC_START + V_SYNC_W);

   // ------------------------------------------------------------------
   // Internal signals
   // ------------------------------------------------------------------
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] div_next;
   logic             adv;
   logic             h_wrap;
   logic [8:0]       h_next;
   logic [8:0]       v_next;
   logic             hb_next;
   logic             vb_next;
   logic             hs_next;
   logic             vs_next;
   logic             fs_next;

   // Divider next-state; adv marks the last divider cycle, where the beam steps.
   always_comb begin
      adv      = (div == DIV_LAST);
      div_next = adv ? '0 : div + 1'b1;
   end

   // Beam counter next-state and all flag decodes taken from the next values,
   // so every registered flag lines up with the counter it describes.
   always_comb begin
      h_wrap  = (HCNT == H_LAST);
      h_next  = h_wrap ? 9'd0 : HCNT + 9'd1;
      v_next  = VCNT;
      if (h_wrap) begin
         v_next = (VCNT == V_LAST) ? 9'd0 : VCNT + 9'd1;
      end
      hb_next = ({1'b0, h_next} >= H_ACT_L);
      vb_next = ({1'b0, v_next} >= V_ACT_L);
      hs_next = ({1'b0, h_next} >= H_HS_LO) && ({1'b0, h_next} < H_HS_HI);
      vs_next = ({1'b0, v_next} >= V_VS_LO) && ({1'b0, v_next} < V_VS_HI);
      fs_next = (h_next == 9'd0) && (v_next == 9'd0);
   end

   // Pixel divider: free-running 0..CLK_DIV-1 count.
   always_ff @(posedge CLK_DRV or negedge RESET_N) begin
      if (!RESET_N) begin
         div <= '0;
      end else begin
         div <= div_next;
      end
   end

   // Pixel clock and strobe, registered from div_next so CLK_VIDEO rises on
   // the same edge the beam outputs change and PIX_CE marks the stepping cycle.
   always_ff @(posedge CLK_DRV or negedge RESET_N) begin
      if (!RESET_N) begin
         CLK_VIDEO <= 1'b0;
         PIX_CE    <= 1'b0;
      end else begin
         CLK_VIDEO <= (div_next < DIV_HALF);
         PIX_CE    <= (div_next == DIV_LAST);
      end
   end

   // Beam counters and sync/blank flags, stepped once per pixel. FRAME_START
   // is a single CLK_DRV cycle wide, so it is cleared on every other cycle.
   always_ff @(posedge CLK_DRV or negedge RESET_N) begin
      if (!RESET_N) begin
         HCNT        <= 9'd0;
         VCNT        <= 9'd0;
         HSYNC       <= 1'b0;
         VSYNC       <= 1'b0;
         HBLANK      <= 1'b0;
         VBLANK      <= 1'b0;
         FRAME_START <= 1'b0;
      end else begin
         FRAME_START <= 1'b0;
         if (adv) begin
            HCNT        <= h_next;
            VCNT        <= v_next;
            HSYNC       <= hs_next;
            VSYNC       <= vs_next;
            HBLANK      <= hb_next;
            VBLANK      <= vb_next;
            FRAME_START <= fs_next;
         end
      end
   end

`ifdef SPACE_RACE_SYNC_TESTPAT_EN
   logic tp_next;

   // Crosshatch: a line every 16 pixels and every 16 lines, active area only.
   always_comb begin
      tp_next = ((h_next[3:0] == 4'd0) || (v_next[3:0] == 4'd0)) && !hb_next && !vb_next;
   end

   // Test pattern register, stepped with the beam counters.
   always_ff @(posedge CLK_DRV or negedge RESET_N) begin
      if (!RESET_N) begin
         TESTPAT <= 1'b0;
      end else if (adv) begin
         TESTPAT <= tp_next;
      end
   end
`else
   assign TESTPAT = 1'b0;
`endif

endmodule

// File: tb/tb_space_race_sync_gen.sv
// Testbench for space_race_sync_gen.
// u_dut uses the default 455x262 timing with CLK_DIV=8 for reset, start-up,
// line and mid-line reset checks. u_small keeps the default vertical timing but
// uses CLK_DIV=2 and a 40-pixel line so a whole frame fits a short run.
module tb_space_race_sync_gen;

   // ---------------- clock / reset ----------------
   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic       rst_n;
   logic       s_rst_n;

   logic       clk_video, pix_ce, hsync, vsync, hblank, vblank, frame_start, testpat;
   logic [8:0] hcnt, vcnt;

   logic       s_clk_video, s_pix_ce, s_hsync, s_vsync, s_hblank, s_vblank, s_frame_start, s_testpat;
   logic [8:0] s_hcnt, s_vcnt;

   space_race_sync_gen u_dut (
      .CLK_DRV     (clk_sys),
      .RESET_N     (rst_n),
      .CLK_VIDEO   (clk_video),
      .PIX_CE      (pix_ce),
      .HCNT        (hcnt),
      .VCNT        (vcnt),
      .HSYNC       (hsync),
      .VSYNC       (vsync),
      .HBLANK      (hblank),
      .VBLANK      (vblank),
      .FRAME_START (frame_start),
      .TESTPAT     (testpat)
   );

   space_race_sync_gen #(
      .CLK_DIV      (2),
      .H_TOTAL      (40),
      .H_ACTIVE     (30),
      .H_SYNC_START (32),
      .H_SYNC_W     (4)
   ) u_small (
      .CLK_DRV     (clk_sys),
      .RESET_N     (s_rst_n),
      .CLK_VIDEO   (s_clk_video),
      .PIX_CE      (s_pix_ce),
      .HCNT        (s_hcnt),
      .VCNT        (s_vcnt),
      .HSYNC       (s_hsync),
      .VSYNC       (s_vsync),
      .HBLANK      (s_hblank),
      .VBLANK      (s_vblank),
      .FRAME_START (s_frame_start),
      .TESTPAT     (s_testpat)
   );

   // ---------------- checking ----------------
   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // One CLK_DRV edge, then sample at the following falling edge.
   task automatic step();
      @(posedge clk_sys);
      @(negedge clk_sys);
   endtask

   // Release u_dut reset and check the start-up timing over 24 edges.
   // CLK_VIDEO after edges 1..24 (bit 0 = edge 1): 111 0000 1111 0000 1111 0000 1
   task automatic restart_check(input string tag);
      logic [23:0] cv;
      int          first_ce;
      logic [8:0]  h_at8;
      logic [8:0]  h_at24;
      logic        fs_seen;
      cv       = '0;
      first_ce = 0;
      h_at8    = 9'h1ff;
      h_at24   = 9'h1ff;
      fs_seen  = 1'b0;
      rst_n    = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         step();
         cv[k-1] = clk_video;
         if (pix_ce && (first_ce == 0)) first_ce = k + 1;
         if (frame_start) fs_seen = 1'b1;
         if (k == 8)  h_at8  = hcnt;
         if (k == 24) h_at24 = hcnt;
      end
      chk({tag, "_first_pix_ce_cycle"}, first_ce, 8);
      chk({tag, "_clk_video_wave"}, cv, 24'b1000_0111_1000_0111_1000_0111);
      chk({tag, "_hcnt_after_first_step"}, h_at8, 1);
      chk({tag, "_hcnt_after_third_step"}, h_at24, 3);
      chk({tag, "_no_frame_start_on_release"}, fs_seen, 0);
      chk({tag, "_vcnt_start"}, vcnt, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int         wraps, t_w1, t_w2;
      logic [8:0] v_w1, v_w2, prev_h, hs_min, hs_max;
      int         hs_cyc, hb_err, hs_err, vflag_err, tp_err;
      logic       hb374, hb375, tp384, reach, exp_tp;
      int         fs_cnt, t_f1, t_f2, fs_wide, fs_pos_err, vs_skew, vs_err, vb_err, sh_err;
      logic [8:0] s_prev_v, vs_min, vs_max, vb_min, vb_max;
      logic       prev_fs, prev_vs;
`ifdef SPACE_RACE_SYNC_TESTPAT_EN
      logic       tp_16_5, tp_3_32, tp_3_5;
`endif

      rst_n   = 1'b0;
      s_rst_n = 1'b0;
      repeat (3) step();

      // Reset state
      chk("rst_hcnt", hcnt, 0);
      chk("rst_vcnt", vcnt, 0);
      chk("rst_flags", {clk_video, pix_ce, hsync, vsync, hblank, vblank, frame_start, testpat}, 0);
      chk("rst_small_all", {s_clk_video, s_pix_ce, s_hsync, s_vsync, s_hblank, s_vblank,
                            s_frame_start, s_testpat, s_hcnt, s_vcnt}, 0);

      // Start-up after release
      restart_check("rel");

      // Two full line wraps on u_dut: HBLANK/HSYNC decode, VCNT step, line length
      wraps = 0; t_w1 = 0; t_w2 = 0; v_w1 = '0; v_w2 = '0;
      hs_min = 9'h1ff; hs_max = 9'h000; hs_cyc = 0;
      hb_err = 0; hs_err = 0; vflag_err = 0; tp_err = 0;
      hb374 = 1'bx; hb375 = 1'bx; tp384 = 1'bx;
      prev_h = hcnt;
      for (int c = 1; c <= 8000 && wraps < 2; c++) begin
         step();
         if (hblank !== (hcnt >= 9'd375)) hb_err++;
         if (hsync !== ((hcnt >= 9'd400) && (hcnt < 9'd432))) hs_err++;
         if ((vblank !== 1'b0) || (vsync !== 1'b0)) vflag_err++;
`ifdef SPACE_RACE_SYNC_TESTPAT_EN
         exp_tp = ((hcnt[3:0] == 4'd0) || (vcnt[3:0] == 4'd0)) && (hcnt < 9'd375) && (vcnt < 9'd240);
`else
         exp_tp = 1'b0;
`endif
         if (testpat !== exp_tp) tp_err++;
         if (hcnt == 9'd374) hb374 = hblank;
         if (hcnt == 9'd375) hb375 = hblank;
         if ((hcnt == 9'd384) && (vcnt == 9'd0)) tp384 = testpat;
         if ((vcnt == 9'd1) && hsync) begin
            hs_cyc++;
            if (hcnt < hs_min) hs_min = hcnt;
            if (hcnt > hs_max) hs_max = hcnt;
         end
         if ((prev_h == 9'd454) && (hcnt == 9'd0)) begin
            wraps++;
            if (wraps == 1) begin
               t_w1 = c;
               v_w1 = vcnt;
            end else begin
               t_w2 = c;
               v_w2 = vcnt;
            end
         end
         prev_h = hcnt;
      end
      chk("line_wraps_seen", wraps, 2);
      chk("line_length_cycles", t_w2 - t_w1, 3640);
      chk("vcnt_after_wrap1", v_w1, 1);
      chk("vcnt_after_wrap2", v_w2, 2);
      chk("hblank_at_374", hb374, 0);
      chk("hblank_at_375", hb375, 1);
      chk("hblank_decode_errs", hb_err, 0);
      chk("hsync_first_hcnt", hs_min, 400);
      chk("hsync_last_hcnt", hs_max, 431);
      chk("hsync_cycles", hs_cyc, 256);
      chk("hsync_decode_errs", hs_err, 0);
      chk("vflags_active_lines", vflag_err, 0);
      chk("testpat_line_errs", tp_err, 0);
      chk("testpat_h384_v0", tp384, 0);

      // Mid-line reset on u_dut: outputs clear without a clock edge
      reach = 1'b0;
      for (int c = 1; c <= 2000 && !reach; c++) begin
         step();
         if (hcnt == 9'd200) reach = 1'b1;
      end
      chk("reach_hcnt_200", reach, 1);
      chk("reach_vcnt_2", vcnt, 2);
      rst_n = 1'b0;
      #1;
      chk("midrst_hcnt", hcnt, 0);
      chk("midrst_vcnt", vcnt, 0);
      chk("midrst_flags", {clk_video, pix_ce, hsync, vsync, hblank, vblank, frame_start, testpat}, 0);
      @(negedge clk_sys);
      step();
      restart_check("mid");

      // Full frames on u_small: vertical timing and FRAME_START
      s_rst_n = 1'b1;
      fs_cnt = 0; t_f1 = 0; t_f2 = 0; fs_wide = 0; fs_pos_err = 0;
      vs_skew = 0; vs_err = 0; vb_err = 0; sh_err = 0; tp_err = 0;
      vs_min = 9'h1ff; vs_max = 9'h000; vb_min = 9'h1ff; vb_max = 9'h000;
      prev_fs = 1'b0; prev_vs = s_vsync; s_prev_v = s_vcnt;
`ifdef SPACE_RACE_SYNC_TESTPAT_EN
      tp_16_5 = 1'bx; tp_3_32 = 1'bx; tp_3_5 = 1'bx;
`endif
      for (int c = 1; c <= 45000 && fs_cnt < 2; c++) begin
         step();
         if (s_vblank !== (s_vcnt >= 9'd240)) vb_err++;
         if (s_vsync !== ((s_vcnt >= 9'd244) && (s_vcnt < 9'd248))) vs_err++;
         if ((s_hblank !== (s_hcnt >= 9'd30)) ||
             (s_hsync !== ((s_hcnt >= 9'd32) && (s_hcnt < 9'd36)))) sh_err++;
         if ((s_vsync !== prev_vs) && (s_vcnt == s_prev_v)) vs_skew++;
         if (s_vsync) begin
            if (s_vcnt < vs_min) vs_min = s_vcnt;
            if (s_vcnt > vs_max) vs_max = s_vcnt;
         end
         if (s_vblank) begin
            if (s_vcnt < vb_min) vb_min = s_vcnt;
            if (s_vcnt > vb_max) vb_max = s_vcnt;
         end
`ifdef SPACE_RACE_SYNC_TESTPAT_EN
         exp_tp = ((s_hcnt[3:0] == 4'd0) || (s_vcnt[3:0] == 4'd0)) && (s_hcnt < 9'd30) && (s_vcnt < 9'd240);
         if ((s_hcnt == 9'd16) && (s_vcnt == 9'd5))  tp_16_5 = s_testpat;
         if ((s_hcnt == 9'd3)  && (s_vcnt == 9'd32)) tp_3_32 = s_testpat;
         if ((s_hcnt == 9'd3)  && (s_vcnt == 9'd5))  tp_3_5  = s_testpat;
`else
         exp_tp = 1'b0;
`endif
         if (s_testpat !== exp_tp) tp_err++;
         if (s_frame_start) begin
            if (prev_fs) begin
               fs_wide++;
            end else begin
               fs_cnt++;
               if (fs_cnt == 1) t_f1 = c;
               else             t_f2 = c;
            end
            if ((s_hcnt != 9'd0) || (s_vcnt != 9'd0)) fs_pos_err++;
         end
         prev_fs  = s_frame_start;
         prev_vs  = s_vsync;
         s_prev_v = s_vcnt;
      end
      chk("frame_start_pulses", fs_cnt, 2);
      chk("first_frame_start_cycle", t_f1, 20960);
      chk("frame_period_cycles", t_f2 - t_f1, 20960);
      chk("frame_start_width_errs", fs_wide, 0);
      chk("frame_start_position_errs", fs_pos_err, 0);
      chk("vblank_first_line", vb_min, 240);
      chk("vblank_last_line", vb_max, 261);
      chk("vblank_decode_errs", vb_err, 0);
      chk("vsync_first_line", vs_min, 244);
      chk("vsync_last_line", vs_max, 247);
      chk("vsync_decode_errs", vs_err, 0);
      chk("vsync_without_vcnt_change", vs_skew, 0);
      chk("small_h_decode_errs", sh_err, 0);
      chk("testpat_frame_errs", tp_err, 0);
`ifdef SPACE_RACE_SYNC_TESTPAT_EN
      chk("testpat_h16_v5", tp_16_5, 1);
      chk("testpat_h3_v32", tp_3_32, 1);
      chk("testpat_h3_v5", tp_3_5, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
